// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream and writes
// it word by word into instruction memory while holding the CPU in reset.
module imem_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  localparam int          TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [16:0] DEPTH = 17'(1 << ADDR_W);

  logic [2:0]       state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [31:0]      asm_q, asm_d;
  logic [7:0]       chk_q, chk_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [15:0]      widx_q, widx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             hold_q, hold_d;
  logic             err_q, err_d;

  logic [15:0] new_len;
  logic        chk_ok;
  logic        last_wr;

  assign new_len = {len_q[15:8], rx_data};
  assign chk_ok  = (rx_data == chk_q);
  // Write cycle of the final word: the checksum byte may already arrive here.
  assign last_wr = we_q && (widx_q == len_q);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    asm_d   = asm_q;
    chk_d   = chk_q;
    bcnt_d  = bcnt_q;
    widx_d  = widx_q;
    tmo_d   = tmo_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEN_HI;
          err_d   = 1'b0;
          chk_d   = 8'h00;
          bcnt_d  = 2'd0;
          widx_d  = 16'd0;
          tmo_d   = '0;
          hold_d  = 1'b1;
        end
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          len_d   = {rx_data, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          len_d = new_len;
          if (new_len == 16'd0) begin
            state_d = S_CHK;
          end else if ({1'b0, new_len} > DEPTH) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (last_wr) begin
          if (!rx_valid) begin
            state_d = S_CHK;
          end else if (chk_ok) begin
            state_d = S_FIN;
            hold_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end else if (rx_valid) begin
          asm_d  = {asm_q[23:0], rx_data};
          chk_d  = chk_q ^ rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {asm_q[23:0], rx_data};
            addr_d  = {{(30-ADDR_W){1'b0}}, widx_q[ADDR_W-1:0], 2'b00};
            widx_d  = widx_q + 16'd1;
          end
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (chk_ok) begin
            state_d = S_FIN;
            hold_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Inter-byte watchdog; any partially assembled word is simply abandoned.
    if (state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHK}) begin
      if (rx_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= 16'd0;
      chk_q   <= 8'h00;
      bcnt_q  <= 2'd0;
      widx_q  <= 16'd0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      bcnt_q  <= bcnt_d;
      widx_q  <= widx_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    asm_q <= asm_d;
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);
  assign error      = err_q;

endmodule
